sw_result_collector: RTL and testbench

SW_RESULT_COLLECTOR -- requirements
Module: sw_result_collector

---
 rtl/sw_result_collector_pkg.sv | 37 +++
 rtl/sw_rec_fifo.sv | 49 ++++
 rtl/sw_result_collector.sv | 149 ++++++++++++++
 tb/tb_sw_result_collector.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_result_collector_pkg.sv
// Shared widths, FSM encoding and record layout for sw_result_collector.
// CALC_BIT / MAX_T_NUM_BIT may be set externally; otherwise the defaults below apply.
`ifndef CALC_BIT
`define CALC_BIT 16
`endif
`ifndef MAX_T_NUM_BIT
`define MAX_T_NUM_BIT 8
`endif

package sw_result_collector_pkg;

   localparam int unsigned CALC_W = `CALC_BIT;
   localparam int unsigned MAXT_W = `MAX_T_NUM_BIT;
   // Target count must hold 2^MAXT_W, hence one extra bit.
   localparam int unsigned TNUM_W = MAXT_W + 1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

   // Record = {q_idx, rec_body_t}; q_idx width is a per-instance parameter.
   typedef struct packed {
      logic [MAXT_W-1:0] match_idx;
      logic [CALC_W-1:0] score;
      logic [TNUM_W-1:0] t_num;
   } rec_body_t;

   localparam int unsigned REC_BODY_W = $bits(rec_body_t);

   function automatic int unsigned rec_width(input int unsigned q_idx_w);
      return q_idx_w + REC_BODY_W;
   endfunction

endpackage

// File: rtl/sw_rec_fifo.sv
// First-word-fall-through record FIFO with synchronous reset and clear.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sw_rec_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // Storage needs no reset: the head is only meaningful while non-empty.
   always_ff @(posedge clk) begin
      if (w_do_push && !(rst || i_clr)) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/sw_result_collector.sv
// Collects per-query best-match records from SmithWaterman into a small FIFO.
// Optional SW_RESULT_THRESH_EN drops records whose best score is below threshold_i.
module sw_result_collector
   import sw_result_collector_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned Q_IDX_BIT  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 busy_i,
   input  logic                 valid_i,
   input  logic                 change_q_i,
   input  logic [CALC_W-1:0]    result_i,
   input  logic [CALC_W-1:0]    max_result_i,
   input  logic [MAXT_W-1:0]    match_idx_i,
   input  logic [CALC_W-1:0]    threshold_i,
   output logic                 rec_valid_o,
   input  logic                 rec_ready_i,
   output logic [Q_IDX_BIT-1:0] rec_q_idx_o,
   output logic [MAXT_W-1:0]    rec_match_idx_o,
   output logic [CALC_W-1:0]    rec_score_o,
   output logic [TNUM_W-1:0]    rec_t_num_o,
   output logic                 ovf_o,
   output logic                 err_o,
   output logic                 done_o
);

   localparam int unsigned          REC_W = rec_width(Q_IDX_BIT);
   localparam logic [TNUM_W-1:0]    T_ONE = 1;
   localparam logic [TNUM_W-1:0]    T_SAT = {1'b1, {MAXT_W{1'b0}}};
   localparam logic [Q_IDX_BIT-1:0] Q_ONE = 1;

   state_e               r_state;
   state_e               w_state_nxt;
   logic                 r_busy_seen;
   logic [TNUM_W-1:0]    r_t_cnt;
   logic [Q_IDX_BIT-1:0] r_q_cnt;
   logic                 r_ovf;
   logic                 r_err;

   logic                 w_accept;
   logic                 w_tgt;
   logic                 w_query;
   logic                 w_keep;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   rec_body_t            w_body;
   rec_body_t            w_head_body;
   logic [Q_IDX_BIT-1:0] w_head_q;
   logic [REC_W-1:0]     w_push_data;
   logic [REC_W-1:0]     w_head_data;
   logic                 w_unused_inputs;

   // A start pulse owns its cycle: any coincident valid_i is ignored.
   assign w_accept = (r_state == StRun) & valid_i & ~start_i;
   assign w_tgt    = w_accept & ~change_q_i;
   assign w_query  = w_accept & change_q_i;

`ifdef SW_RESULT_THRESH_EN
   assign w_keep          = (max_result_i >= threshold_i);
   assign w_unused_inputs = ^result_i;
`else
   assign w_keep          = 1'b1;
   assign w_unused_inputs = ^{result_i, threshold_i};
`endif

   assign w_push = w_query & w_keep;
   assign w_pop  = rec_valid_o & rec_ready_i;

   always_comb begin
      w_body           = '0;
      w_body.match_idx = match_idx_i;
      w_body.score     = max_result_i;
      w_body.t_num     = r_t_cnt + T_ONE;
   end

   assign w_push_data = {r_q_cnt, w_body};

   sw_rec_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (start_i),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_data  (w_head_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign {w_head_q, w_head_body} = w_head_data;

   // Fields read as zero whenever no record is presented.
   assign rec_valid_o     = ~w_empty;
   assign rec_q_idx_o     = w_empty ? '0 : w_head_q;
   assign rec_match_idx_o = w_empty ? '0 : w_head_body.match_idx;
   assign rec_score_o     = w_empty ? '0 : w_head_body.score;
   assign rec_t_num_o     = w_empty ? '0 : w_head_body.t_num;

   assign ovf_o  = r_ovf;
   assign err_o  = r_err;
   assign done_o = (r_state == StDone);

   always_comb begin
      w_state_nxt = r_state;
      if (start_i) begin
         w_state_nxt = StRun;
      end else begin
         unique case (r_state)
            StIdle:  w_state_nxt = StIdle;
            StRun:   if (r_busy_seen && !busy_i) w_state_nxt = StDrain;
            StDrain: if (w_empty) w_state_nxt = StDone;
            StDone:  w_state_nxt = StDone;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= StIdle;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst || start_i) begin
         r_busy_seen <= 1'b0;
         r_t_cnt     <= '0;
         r_q_cnt     <= '0;
         r_ovf       <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         if ((r_state == StRun) && busy_i) r_busy_seen <= 1'b1;
         if (w_tgt && (r_t_cnt != T_SAT)) r_t_cnt <= r_t_cnt + T_ONE;
         if (w_query) begin
            r_t_cnt <= '0;
            r_q_cnt <= r_q_cnt + Q_ONE;
            if ({1'b0, match_idx_i} > r_t_cnt) r_err <= 1'b1;
         end
         if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sw_result_collector.sv
// Randomized self-checking bench for sw_result_collector against a queue-based model.
// Honours SW_RESULT_THRESH_EN when the design is built with it.
module tb_sw_result_collector;
   import sw_result_collector_pkg::*;

   localparam int DEPTH = 4;
   localparam int QW    = 8;

   logic              clk = 1'b0;
   logic              rst, start_i, busy_i, valid_i, change_q_i, rec_ready_i;
   logic [CALC_W-1:0] result_i, max_result_i, threshold_i;
   logic [MAXT_W-1:0] match_idx_i;
   logic              rec_valid_o, ovf_o, err_o, done_o;
   logic [QW-1:0]     rec_q_idx_o;
   logic [MAXT_W-1:0] rec_match_idx_o;
   logic [CALC_W-1:0] rec_score_o;
   logic [TNUM_W-1:0] rec_t_num_o;

   localparam int RW = QW + MAXT_W + CALC_W + TNUM_W;

   typedef struct {int q; int m; int s; int t;} rec_t;

   rec_t exp_q[$];
   int   m_q, m_t;
   bit   m_ovf, m_err;
   int   n_total = 0;
   int   n_bad   = 0;

   sw_result_collector #(
      .FIFO_DEPTH (DEPTH),
      .Q_IDX_BIT  (QW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start_i         (start_i),
      .busy_i          (busy_i),
      .valid_i         (valid_i),
      .change_q_i      (change_q_i),
      .result_i        (result_i),
      .max_result_i    (max_result_i),
      .match_idx_i     (match_idx_i),
      .threshold_i     (threshold_i),
      .rec_valid_o     (rec_valid_o),
      .rec_ready_i     (rec_ready_i),
      .rec_q_idx_o     (rec_q_idx_o),
      .rec_match_idx_o (rec_match_idx_o),
      .rec_score_o     (rec_score_o),
      .rec_t_num_o     (rec_t_num_o),
      .ovf_o           (ovf_o),
      .err_o           (err_o),
      .done_o          (done_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [RW-1:0] pack_rec(input rec_t r);
      return {QW'(r.q), MAXT_W'(r.m), CALC_W'(r.s), TNUM_W'(r.t)};
   endfunction

   function automatic logic [RW-1:0] dut_rec();
      return {rec_q_idx_o, rec_match_idx_o, rec_score_o, rec_t_num_o};
   endfunction

   // Model assumes no pop coincides with the push unless the caller pops exp_q itself.
   function automatic void model_query(input int mi, input int sc);
      rec_t r;
      bit   keep;
`ifdef SW_RESULT_THRESH_EN
      keep = (sc >= int'(threshold_i));
`else
      keep = 1'b1;
`endif
      r = '{q: m_q % (1 << QW), m: mi, s: sc, t: m_t + 1};
      if (mi > m_t) m_err = 1'b1;
      if (keep) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(r);
         else m_ovf = 1'b1;
      end
      m_q = m_q + 1;
      m_t = 0;
   endfunction

   task automatic do_start();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      m_q = 0; m_t = 0; m_ovf = 1'b0; m_err = 1'b0;
      exp_q.delete();
   endtask

   task automatic send_target();
      valid_i = 1'b1; change_q_i = 1'b0; result_i = CALC_W'($urandom);
      step();
      valid_i = 1'b0;
      m_t = (m_t < (1 << MAXT_W)) ? m_t + 1 : (1 << MAXT_W);
   endtask

   task automatic send_query(input int mi, input int sc);
      valid_i = 1'b1; change_q_i = 1'b1;
      match_idx_i = MAXT_W'(mi); max_result_i = CALC_W'(sc); result_i = CALC_W'($urandom);
      model_query(mi, sc);
      step();
      valid_i = 1'b0; change_q_i = 1'b0;
   endtask

   // Pops every expected record, comparing each as it is accepted.
   task automatic collect(input int max_cycles, input bit rand_ready);
      rec_t e;
      int   cyc = 0;
      while (exp_q.size() > 0 && cyc < max_cycles) begin
         rec_ready_i = rand_ready ? 1'($urandom % 2) : 1'b1;
         #1;
         if (rec_valid_o && rec_ready_i) begin
            e = exp_q.pop_front();
            n_total++;
            if (dut_rec() !== pack_rec(e)) begin
               n_bad++;
               $display("FAIL record: got %h want %h", dut_rec(), pack_rec(e));
            end
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      rec_ready_i = 1'b0;
      #1;
      n_total++;
      if (exp_q.size() != 0 || rec_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL drain: left=%0d rec_valid=%b want 0/0", exp_q.size(), rec_valid_o);
      end
   endtask

   task automatic wait_done(input string tag);
      int c = 0;
      while (done_o !== 1'b1 && c < 20) begin
         step();
         c++;
      end
      n_total++;
      if (done_o !== 1'b1) begin
         n_bad++;
         $display("FAIL %s done: got %b want 1", tag, done_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      n_total++;
      if ({rec_valid_o, ovf_o, err_o, done_o} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset flags: got %b want 0000", {rec_valid_o, ovf_o, err_o, done_o});
      end
      n_total++;
      if (dut_rec() !== '0) begin
         n_bad++;
         $display("FAIL reset fields: got %h want 0", dut_rec());
      end
   endtask

   task automatic test_single();
      rec_t      c;
      logic [RW-1:0] want;
      do_start();
      busy_i = 1'b1; rec_ready_i = 1'b1; threshold_i = '0;
      send_target();
      send_target();
      send_query(1, 42);
      c = '{q: 0, m: 1, s: 42, t: 3};
      want = pack_rec(c);
      n_total++;
      if (rec_valid_o !== 1'b1 || dut_rec() !== want) begin
         n_bad++;
         $display("FAIL single: valid=%b rec=%h want 1 %h", rec_valid_o, dut_rec(), want);
      end
      collect(10, 1'b0);
      busy_i = 1'b0;
      wait_done("single");
   endtask

   task automatic test_overflow();
      logic [RW-1:0] held;
      do_start();
      busy_i = 1'b1; rec_ready_i = 1'b0; threshold_i = '0;
      for (int i = 0; i < 5; i++) begin
         int nt = $urandom_range(0, 3);
         for (int k = 0; k < nt; k++) send_target();
         send_query($urandom_range(0, nt), $urandom_range(0, 1000));
      end
      n_total++;
      if (ovf_o !== m_ovf || m_ovf !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf: got %b want %b", ovf_o, m_ovf);
      end
      held = dut_rec();
      for (int i = 0; i < 3; i++) step();
      n_total++;
      if (rec_valid_o !== 1'b1 || dut_rec() !== pack_rec(exp_q[0]) || dut_rec() !== held) begin
         n_bad++;
         $display("FAIL hold: rec=%h want %h", dut_rec(), pack_rec(exp_q[0]));
      end
      n_total++;
      if (err_o !== m_err) begin
         n_bad++;
         $display("FAIL ovf err: got %b want %b", err_o, m_err);
      end
      collect(30, 1'b1);
   endtask

   task automatic test_push_pop_full();
      rec_t e;
      do_start();
      busy_i = 1'b1; rec_ready_i = 1'b0; threshold_i = '0;
      for (int i = 0; i < DEPTH; i++) send_query(0, $urandom_range(0, 500));
      e = exp_q.pop_front();
      rec_ready_i = 1'b1;
      valid_i = 1'b1; change_q_i = 1'b1;
      match_idx_i = '0; max_result_i = CALC_W'(77);
      model_query(0, 77);
      #1;
      n_total++;
      if (dut_rec() !== pack_rec(e)) begin
         n_bad++;
         $display("FAIL pp head: got %h want %h", dut_rec(), pack_rec(e));
      end
      step();
      valid_i = 1'b0; change_q_i = 1'b0; rec_ready_i = 1'b0;
      n_total++;
      if (ovf_o !== 1'b0 || exp_q.size() != DEPTH) begin
         n_bad++;
         $display("FAIL pp ovf: got %b want 0", ovf_o);
      end
      collect(20, 1'b0);
   endtask

   task automatic test_restart();
      do_start();
      busy_i = 1'b1; rec_ready_i = 1'b0;
      send_query(0, 11);
      send_query(0, 12);
      do_start();
      n_total++;
      if (rec_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL restart valid: got %b want 0", rec_valid_o);
      end
      busy_i = 1'b1;
      send_target();
      send_query(1, 99);
      n_total++;
      if (rec_valid_o !== 1'b1 || rec_q_idx_o !== '0) begin
         n_bad++;
         $display("FAIL restart q_idx: valid=%b q=%0d want 1 0", rec_valid_o, rec_q_idx_o);
      end
      collect(10, 1'b0);
   endtask

   task automatic test_err_done();
      do_start();
      busy_i = 1'b1; rec_ready_i = 1'b1;
      send_target();
      send_target();
      send_query(5, $urandom_range(0, 300));
      n_total++;
      if (err_o !== 1'b1 || m_err !== 1'b1) begin
         n_bad++;
         $display("FAIL err: got %b want 1", err_o);
      end
      collect(10, 1'b0);
      busy_i = 1'b0;
      wait_done("err");
      // A query outside RUN must leave nothing behind.
      valid_i = 1'b1; change_q_i = 1'b1;
      step();
      valid_i = 1'b0; change_q_i = 1'b0;
      n_total++;
      if (rec_valid_o !== 1'b0 || done_o !== 1'b1 || err_o !== 1'b1) begin
         n_bad++;
         $display("FAIL idle query: valid=%b done=%b err=%b want 0 1 1",
                  rec_valid_o, done_o, err_o);
      end
   endtask

   task automatic test_rst_priority();
      do_start();
      busy_i = 1'b1; rec_ready_i = 1'b0;
      send_target();
      send_query(3, 5);
      send_query(0, 6);
      rst = 1'b1; start_i = 1'b1;
      step();
      rst = 1'b0; start_i = 1'b0;
      exp_q.delete();
      valid_i = 1'b1; change_q_i = 1'b1;
      step();
      valid_i = 1'b0; change_q_i = 1'b0;
      n_total++;
      if ({rec_valid_o, err_o, ovf_o, done_o} !== 4'b0000) begin
         n_bad++;
         $display("FAIL rst prio: got %b want 0000", {rec_valid_o, err_o, ovf_o, done_o});
      end
   endtask

`ifdef SW_RESULT_THRESH_EN
   task automatic test_thresh();
      do_start();
      busy_i = 1'b1; rec_ready_i = 1'b0; threshold_i = CALC_W'(30);
      send_query(0, 20);
      send_query(0, 40);
      n_total++;
      if (rec_valid_o !== 1'b1 || rec_q_idx_o !== QW'(1)) begin
         n_bad++;
         $display("FAIL thresh: valid=%b q=%0d want 1 1", rec_valid_o, rec_q_idx_o);
      end
      collect(10, 1'b0);
      threshold_i = '0;
   endtask
`endif

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         int n = $urandom_range(1, 6);
         threshold_i = CALC_W'($urandom_range(0, 255));
         do_start();
         busy_i = 1'b1; rec_ready_i = 1'b0;
         for (int i = 0; i < n; i++) begin
            int nt = $urandom_range(0, 4);
            for (int k = 0; k < nt; k++) send_target();
            if ($urandom_range(0, 1) == 1) step();
            send_query($urandom_range(0, nt + 1), $urandom_range(0, 255));
         end
         n_total++;
         if (ovf_o !== m_ovf || err_o !== m_err) begin
            n_bad++;
            $display("FAIL rand%0d flags: ovf=%b err=%b want %b %b", it, ovf_o, err_o, m_ovf, m_err);
         end
         busy_i = 1'b0;
         collect(100, 1'b1);
         wait_done("rand");
      end
      threshold_i = '0;
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; busy_i = 1'b0; valid_i = 1'b0; change_q_i = 1'b0;
      rec_ready_i = 1'b0; result_i = '0; max_result_i = '0; match_idx_i = '0; threshold_i = '0;
      m_q = 0; m_t = 0; m_ovf = 1'b0; m_err = 1'b0;
      test_reset();
      test_single();
      test_overflow();
      test_push_pop_full();
      test_restart();
      test_err_done();
      test_rst_priority();
`ifdef SW_RESULT_THRESH_EN
      test_thresh();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
